// File: rtl/cmd_frame_gen.sv
// Command framer: turns one register-file / ALU command into a short byte frame
// for a UART transmitter, with ready/valid handshakes on both sides.
module cmd_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_type,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [DATA_WIDTH-1:0] cmd_opb,
    input  logic [3:0]            cmd_fun,
    output logic [DATA_WIDTH-1:0] byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  frame_done,
    output logic [1:0]            rsp_bytes,
    output logic [7:0]            frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_WR  = 2'b00;
    localparam logic [1:0] TYPE_RD  = 2'b01;
    localparam logic [1:0] TYPE_ALU = 2'b10;

    localparam logic [DATA_WIDTH-1:0] HDR_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU0 = DATA_WIDTH'(8'hDD);

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              type_q, type_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic [3:0]              fun_q, fun_d;
    logic [1:0]              rsp_q, rsp_d;
    logic [7:0]              cnt_q, cnt_d;

    logic [1:0]              last_idx;
    logic [1:0]              rsp_for_type;
    logic [DATA_WIDTH-1:0]   frame_byte;

    // Frame length and expected response size depend only on the latched type.
    always_comb begin
        last_idx     = 2'd1;
        rsp_for_type = 2'd2;
        case (type_q)
            TYPE_WR: begin
                last_idx     = 2'd2;
                rsp_for_type = 2'd0;
            end
            TYPE_RD: begin
                last_idx     = 2'd1;
                rsp_for_type = 2'd1;
            end
            TYPE_ALU: begin
                last_idx     = 2'd3;
                rsp_for_type = 2'd2;
            end
            default: begin
                last_idx     = 2'd1;
                rsp_for_type = 2'd2;
            end
        endcase
    end

    // Byte selected by the current index, built only from latched fields.
    always_comb begin
        frame_byte = '0;
        case (type_q)
            TYPE_WR: begin
                case (idx_q)
                    2'd0:    frame_byte = HDR_WR;
                    2'd1:    frame_byte = DATA_WIDTH'(addr_q);
                    2'd2:    frame_byte = data_q;
                    default: frame_byte = '0;
                endcase
            end
            TYPE_RD: begin
                case (idx_q)
                    2'd0:    frame_byte = HDR_RD;
                    2'd1:    frame_byte = DATA_WIDTH'(addr_q);
                    default: frame_byte = '0;
                endcase
            end
            TYPE_ALU: begin
                case (idx_q)
                    2'd0:    frame_byte = HDR_ALU;
                    2'd1:    frame_byte = data_q;
                    2'd2:    frame_byte = opb_q;
                    default: frame_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            default: begin
                case (idx_q)
                    2'd0:    frame_byte = HDR_ALU0;
                    2'd1:    frame_byte = DATA_WIDTH'(fun_q);
                    default: frame_byte = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        type_d     = type_q;
        addr_d     = addr_q;
        data_d     = data_q;
        opb_d      = opb_q;
        fun_d      = fun_q;
        rsp_d      = rsp_q;
        cnt_d      = cnt_q;
        cmd_ready  = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    type_d  = cmd_type;
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    opb_d   = cmd_opb;
                    fun_d   = cmd_fun;
                    idx_d   = 2'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                byte_valid = 1'b1;
                byte_out   = frame_byte;
                if (byte_ready) begin
                    if (idx_q == last_idx) begin
                        // Response size becomes visible together with frame_done.
                        rsp_d   = rsp_for_type;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                cnt_d      = cnt_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            type_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            opb_q   <= '0;
            fun_q   <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            opb_q   <= opb_d;
            fun_q   <= fun_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_bytes = rsp_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_cmd_frame_gen.sv
// Bench for cmd_frame_gen: a frame-level model checks every cycle, directed
// tests pin byte sequences, latency, backpressure, reset abort and counter wrap.
module tb_cmd_frame_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = '0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic [7:0] cmd_opb = '0;
    logic [3:0] cmd_fun = '0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       frame_done;
    logic [1:0] rsp_bytes;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    cmd_frame_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_opb    (cmd_opb),
        .cmd_fun    (cmd_fun),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_done (frame_done),
        .rsp_bytes  (rsp_bytes),
        .frame_cnt  (frame_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] hs_log[$];
    logic [7:0] tr_log[$];
    bit         busy = 1'b0;
    int         model_cnt = 0;
    logic [1:0] cur_rsp = '0;
    logic [1:0] pend_rsp = '0;
    logic [1:0] done_rsp = '0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         first_valid_cyc = 0;
    int         done_cyc = 0;
    bit         seen_valid = 1'b0;

    function automatic void push_frame(input logic [1:0] t, input logic [3:0] a,
                                       input logic [7:0] d, input logic [7:0] b,
                                       input logic [3:0] f);
        case (t)
            2'b00: begin exp_q.push_back(8'hAA); exp_q.push_back({4'h0, a}); exp_q.push_back(d); pend_rsp = 2'd0; end
            2'b01: begin exp_q.push_back(8'hBB); exp_q.push_back({4'h0, a}); pend_rsp = 2'd1; end
            2'b10: begin exp_q.push_back(8'hCC); exp_q.push_back(d); exp_q.push_back(b); exp_q.push_back({4'h0, f}); pend_rsp = 2'd2; end
            default: begin exp_q.push_back(8'hDD); exp_q.push_back({4'h0, f}); pend_rsp = 2'd2; end
        endcase
    endfunction

    // One compare process: expectations come from the model's view of the frame in flight.
    always @(negedge CLK) begin
        bit exp_done;
        cyc++;
        if (RST) begin
            exp_q.delete();
            busy      = 1'b0;
            model_cnt = 0;
            cur_rsp   = '0;
        end else begin
            exp_done = busy && (exp_q.size() == 0);
            chk("cmd_ready", cmd_ready, !busy);
            chk("byte_valid", byte_valid, exp_q.size() > 0);
            chk("byte_out", byte_out, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
            chk("frame_done", frame_done, exp_done);
            if (exp_done) cur_rsp = pend_rsp;
            chk("rsp_bytes", rsp_bytes, cur_rsp);
            chk("frame_cnt", frame_cnt, model_cnt);
            if (byte_valid) tr_log.push_back(byte_out);
            if (byte_valid && !seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (exp_done) begin
                done_rsp  = rsp_bytes;
                done_cyc  = cyc;
                $display("frame %0d done: rsp_bytes=%0d frame_cnt=%0d", model_cnt + 1, rsp_bytes, frame_cnt);
                model_cnt = (model_cnt + 1) % 256;
                busy      = 1'b0;
            end else if (exp_q.size() > 0) begin
                if (byte_ready) begin
                    hs_log.push_back(byte_out);
                    void'(exp_q.pop_front());
                end
            end else if (!busy && cmd_valid) begin
                push_frame(cmd_type, cmd_addr, cmd_data, cmd_opb, cmd_fun);
                busy       = 1'b1;
                acc_cyc    = cyc;
                seen_valid = 1'b0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                            input logic [7:0] b, input logic [3:0] f);
        int n;
        cmd_type  = t;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_opb   = b;
        cmd_fun   = f;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got cmd_ready=0, expected 1 within 50 cycles");
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (frame_done) break;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got frame_done=0, expected 1 within 100 cycles");
        end
        step();
    endtask

    task automatic check_q(input string name, input logic [7:0] got[$], input logic [7:0] want[$]);
        chk({name, "_len"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s[%0d]", name, i), got[i], want[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_byte_valid"}, byte_valid, 1'b0);
        chk({tag, "_byte_out"}, byte_out, 8'h00);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_rsp_bytes"}, rsp_bytes, 2'd0);
        chk({tag, "_frame_cnt"}, frame_cnt, 8'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] want[$];

        // Reset state
        repeat (3) step();
        RST = 1'b0;
        check_reset_outputs("reset");

        // Write frame, byte_ready held high (also high while idle, where it is ignored)
        byte_ready = 1'b1;
        step();
        hs_log.delete();
        tr_log.delete();
        send_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 4'h0);
        wait_done();
        want = '{8'hAA, 8'h05, 8'h3C};
        check_q("wr_bytes", hs_log, want);
        check_q("wr_trace", tr_log, want);
        chk("wr_first_valid_lat", first_valid_cyc - acc_cyc, 1);
        chk("wr_frame_time", done_cyc - acc_cyc + 1, 5);
        chk("wr_rsp", done_rsp, 2'd0);
        chk("wr_cnt", frame_cnt, 8'd1);

        // ALU frame with operands
        hs_log.delete();
        send_cmd(2'b10, 4'h0, 8'h12, 8'h34, 4'h1);
        wait_done();
        want = '{8'hCC, 8'h12, 8'h34, 8'h01};
        check_q("alu_bytes", hs_log, want);
        chk("alu_rsp", done_rsp, 2'd2);
        chk("alu_cnt", frame_cnt, 8'd2);

        // Read frame with 3 stall cycles per byte
        byte_ready = 1'b0;
        hs_log.delete();
        tr_log.delete();
        send_cmd(2'b01, 4'h2, 8'h00, 8'h00, 4'h0);
        for (int b = 0; b < 2; b++) begin
            repeat (3) step();
            byte_ready = 1'b1;
            step();
            byte_ready = 1'b0;
        end
        wait_done();
        want = '{8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'h02, 8'h02, 8'h02, 8'h02};
        check_q("bp_trace", tr_log, want);
        want = '{8'hBB, 8'h02};
        check_q("bp_bytes", hs_log, want);
        chk("bp_rsp", done_rsp, 2'd1);

        // Command inputs change and cmd_valid pulses while a frame is in flight
        hs_log.delete();
        send_cmd(2'b00, 4'h9, 8'h5A, 8'h00, 4'h0);
        cmd_type  = 2'b11;
        cmd_addr  = 4'h1;
        cmd_data  = 8'hFF;
        cmd_fun   = 4'hF;
        cmd_valid = 1'b1;
        repeat (2) step();
        cmd_valid  = 1'b0;
        byte_ready = 1'b1;
        wait_done();
        repeat (3) step();
        want = '{8'hAA, 8'h09, 8'h5A};
        check_q("ign_bytes", hs_log, want);
        chk("ign_cnt", frame_cnt, 8'd4);
        chk("ign_idle_valid", byte_valid, 1'b0);

        // Reset after the second byte of an ALU frame aborts it
        hs_log.delete();
        send_cmd(2'b10, 4'h0, 8'h11, 8'h22, 4'h3);
        repeat (2) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_reset_outputs("abort");
        want = '{8'hCC, 8'h11};
        check_q("abort_bytes", hs_log, want);
        repeat (4) step();
        chk("abort_no_done_cnt", frame_cnt, 8'd0);
        hs_log.delete();
        send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 4'h7);
        wait_done();
        want = '{8'hDD, 8'h07};
        check_q("restart_bytes", hs_log, want);
        chk("restart_rsp", done_rsp, 2'd2);
        chk("restart_cnt", frame_cnt, 8'd1);

        // Counter wrap: 256 frames from zero
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("wrap_start_cnt", frame_cnt, 8'd0);
        for (int i = 0; i < 256; i++) begin
            send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 4'(i));
            wait_done();
            if (i == 254) chk("wrap_cnt_255", frame_cnt, 8'd255);
        end
        chk("wrap_cnt_0", frame_cnt, 8'd0);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_frame_gen.md
CMD_FRAME_GEN -- requirements
Module: cmd_frame_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of frame bytes and data fields.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register address width.
REQ-003 SHALL have CLK  input  1  single clock; all logic rises on CLK.
REQ-004 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have cmd_valid  input  1  command request.
REQ-006 SHALL have cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have cmd_type  input  2  00 RF write, 01 RF read, 10 ALU with operands, 11 ALU no operands.
REQ-008 SHALL have cmd_addr  input  ADDR_WIDTH  register address.
REQ-009 SHALL have cmd_data  input  DATA_WIDTH  write data, or operand A for type 10.
REQ-010 SHALL have cmd_opb  input  DATA_WIDTH  operand B for type 10.
REQ-011 SHALL have cmd_fun  input  4  ALU function code.
REQ-012 SHALL have byte_out  output  DATA_WIDTH  frame byte toward the UART transmitter.
REQ-013 SHALL have byte_valid  output  1  byte_out valid.
REQ-014 SHALL have byte_ready  input  1  consumer takes byte when byte_valid & byte_ready.
REQ-015 SHALL have frame_done  output  1  one-cycle pulse after last byte of a frame.
REQ-016 SHALL have rsp_bytes  output  2  response bytes the system returns for the completed frame; valid with frame_done.
REQ-017 SHALL have frame_cnt  output  8  count of completed frames.

Function
REQ-018 SHALL send frames: type 00 = AA, addr, data; 01 = BB, addr; 10 = CC, A, B, fun; 11 = DD, fun (hex bytes, in this order).
REQ-019 SHALL zero-extend addr and fun to DATA_WIDTH in their bytes.
REQ-020 SHALL implement states IDLE, SEND, DONE.
REQ-021 IDLE: cmd_ready=1, byte_valid=0; on cmd_valid latch all cmd fields, clear byte index, go to SEND.
REQ-022 SEND: cmd_ready=0, byte_valid=1, byte_out = frame byte at index; on byte_ready increment index; on byte_ready at last index go to DONE.
REQ-023 DONE: frame_done=1 and byte_valid=0 for exactly one cycle, frame_cnt increments, then go to IDLE.
REQ-024 First byte_valid SHALL assert the cycle after acceptance; minimum frame time = bytes+2 cycles with byte_ready held high.
REQ-025 byte_out SHALL hold stable while byte_valid=1 and byte_ready=0; cmd input changes after acceptance SHALL NOT affect the frame.
REQ-026 rsp_bytes SHALL be 0 for type 00, 1 for type 01, 2 for types 10 and 11; it holds its value until the next DONE.
REQ-027 frame_cnt SHALL wrap 255 -> 0.
REQ-028 byte_ready asserted in IDLE or DONE SHALL be ignored; cmd_valid outside IDLE SHALL be ignored.
REQ-029 byte_out SHALL be 0 whenever byte_valid=0.

Reset
REQ-030 On RST=1 at a CLK edge: state IDLE, cmd_ready=1, byte_valid=0, byte_out=0, frame_done=0, rsp_bytes=0, frame_cnt=0, latched fields=0.
REQ-031 RST mid-frame SHALL abort the frame with no frame_done; the next accepted command restarts from its first byte.

Verification
REQ-032 Write: type 00, addr 5, data 3C, byte_ready=1 -> bytes AA,05,3C on consecutive cycles; frame_done with rsp_bytes=0; frame_cnt=1.
REQ-033 ALU: type 10, A=12, B=34, fun=1 -> CC,12,34,01; rsp_bytes=2.
REQ-034 Backpressure: type 01, addr 2, byte_ready low 3 cycles per byte -> BB held 4 cycles, then 02 held 4 cycles; no byte lost or duplicated.
REQ-035 Ignored inputs: cmd_valid pulsed during SEND; fields changed after accept -> in-flight frame unchanged; second command not accepted.
REQ-036 Reset: RST after the 2nd byte of a type-10 frame -> outputs at reset values next cycle, no frame_done; new type-11 fun=7 -> DD,07.
REQ-037 Counter wrap: 256 type-11 frames -> frame_cnt returns to 0.
